// File: rtl/dm_mmio.sv
// rtl/dm_mmio.sv - word memory plus LED, switch-edge and timer registers on one MMIO bus
// Reads are registered (1-cycle latency); register reads return pre-update state.
module dm_mmio #(
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 8192,
  parameter int SW_W      = 10,
  parameter int LED_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic              re,
  input  logic              we,
  input  logic [DATA_W-1:0] wrt_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic [SW_W-1:0]   SW,
  output logic [LED_W-1:0]  LEDR,
  output logic              irq
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [15:0] A_LED   = 16'hC000;
  localparam logic [15:0] A_SW    = 16'hC001;
  localparam logic [15:0] A_EDGE  = 16'hC002;
  localparam logic [15:0] A_COUNT = 16'hC003;
  localparam logic [15:0] A_CMP   = 16'hC004;
  localparam logic [15:0] A_CTRL  = 16'hC005;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [LED_W-1:0]  led_q, led_d;
  logic [SW_W-1:0]   s1_q, s2_q, s3_q;
  logic [SW_W-1:0]   edge_q, edge_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       cmp_q, cmp_d;
  logic              en_q, en_d;
  logic              autoclr_q, autoclr_d;
  logic              flag_q, flag_d;
  logic              ie_q, ie_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              rd_en, wr_en;
  logic              mem_sel, mem_hit;
  logic              match;
  logic [AW-1:0]     mem_idx;
  logic [DATA_W-1:0] rd_mux;

  // Simultaneous re and we is a collision: neither side is performed.
  assign rd_en   = re & ~we;
  assign wr_en   = we & ~re;
  assign mem_sel = (addr[15:13] == 3'd0);
  assign mem_hit = mem_sel && ({3'b000, addr[12:0]} < 16'(MEM_DEPTH));
  assign mem_idx = addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rst && wr_en && mem_hit) begin
      mem_q[mem_idx] <= wrt_data;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (mem_sel) begin
      if (mem_hit) begin
        rd_mux = mem_q[mem_idx];
      end
    end else begin
      case (addr)
        A_LED:   rd_mux = DATA_W'(led_q);
        A_SW:    rd_mux = DATA_W'(s2_q);
        A_EDGE:  rd_mux = DATA_W'(edge_q);
        A_COUNT: rd_mux = DATA_W'(count_q);
        A_CMP:   rd_mux = DATA_W'(cmp_q);
        A_CTRL:  rd_mux = DATA_W'({ie_q, flag_q, autoclr_q, en_q});
        default: rd_mux = '0;
      endcase
    end
  end

  always_comb begin
    led_d     = led_q;
    cmp_d     = cmp_q;
    en_d      = en_q;
    autoclr_d = autoclr_q;
    ie_d      = ie_q;
    flag_d    = flag_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;

    // Match is judged on the pre-write COUNT, so a same-cycle load cannot hide it.
    match = en_q && (count_q == cmp_q);

    edge_d = (edge_q & ~((wr_en && addr == A_EDGE) ? wrt_data[SW_W-1:0] : '0))
           | (s2_q & ~s3_q);

    if (match) begin
      flag_d = 1'b1;
    end else if (wr_en && addr == A_CTRL && wrt_data[2]) begin
      flag_d = 1'b0;
    end

    if (wr_en && addr == A_COUNT) begin
      count_d = 16'(wrt_data);
    end else if (en_q) begin
      count_d = (match && autoclr_q) ? 16'h0000 : count_q + 16'h0001;
    end

    if (wr_en && addr == A_LED) begin
      led_d = wrt_data[LED_W-1:0];
    end
    if (wr_en && addr == A_CMP) begin
      cmp_d = 16'(wrt_data);
    end
    if (wr_en && addr == A_CTRL) begin
      en_d      = wrt_data[0];
      autoclr_d = wrt_data[1];
      ie_d      = wrt_data[3];
    end

    irq_d = flag_d & ie_d;

    if (rd_en) begin
      rd_data_d = rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      edge_q    <= '0;
      count_q   <= 16'h0000;
      cmp_q     <= 16'hFFFF;
      en_q      <= 1'b0;
      autoclr_q <= 1'b0;
      flag_q    <= 1'b0;
      ie_q      <= 1'b0;
      irq_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      led_q     <= led_d;
      s1_q      <= SW;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      edge_q    <= edge_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      autoclr_q <= autoclr_d;
      flag_q    <= flag_d;
      ie_q      <= ie_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign LEDR    = led_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_dm_mmio.sv
// tb/tb_dm_mmio.sv - scoreboard bench for dm_mmio with a cycle-level reference model
// Directed scenarios followed by randomized bus traffic, reads checked through a queue.
module tb_dm_mmio;

  localparam int DW    = 16;
  localparam int DEPTH = 4096;
  localparam int SWW   = 10;
  localparam int LEDW  = 10;

  logic            clk = 1'b0;
  logic            rst, re, we;
  logic [15:0]     addr;
  logic [DW-1:0]   wrt_data, rd_data;
  logic [SWW-1:0]  sw_v;
  logic [LEDW-1:0] LEDR;
  logic            irq;

  always #5 clk = ~clk;

  dm_mmio #(.DATA_W(DW), .MEM_DEPTH(DEPTH), .SW_W(SWW), .LED_W(LEDW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .wrt_data(wrt_data),
    .rd_data(rd_data), .SW(sw_v), .LEDR(LEDR), .irq(irq)
  );

  // Reference model state: what the spec says the block holds after each edge.
  logic [15:0]     m_mem [DEPTH];
  logic [LEDW-1:0] m_led;
  logic [SWW-1:0]  m_s1, m_s2, m_s3, m_edge;
  logic [15:0]     m_count, m_cmp, m_rd;
  bit              m_en, m_ac, m_flag, m_ie, m_irq, m_rvld;
  logic [15:0]     exp_q [$];
  int              checks = 0;
  int              errors = 0;
  bit              mon_on = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic bit in_mem(input logic [15:0] a);
    return (a[15:13] == 3'd0) && ({19'b0, a[12:0]} < 32'(DEPTH));
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a[15:13] == 3'd0) return in_mem(a) ? m_mem[a[11:0]] : 16'h0000;
    case (a)
      16'hC000: return {6'b0, m_led};
      16'hC001: return {6'b0, m_s2};
      16'hC002: return {6'b0, m_edge};
      16'hC003: return m_count;
      16'hC004: return m_cmp;
      16'hC005: return {12'b0, m_ie, m_flag, m_ac, m_en};
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic model_step();
    bit rd, wr, match;
    logic [15:0] d;
    d = wrt_data;
    if (rst) begin
      m_led = '0; m_s1 = '0; m_s2 = '0; m_s3 = '0; m_edge = '0;
      m_count = 16'h0000; m_cmp = 16'hFFFF; m_rd = 16'h0000;
      m_en = 0; m_ac = 0; m_flag = 0; m_ie = 0; m_irq = 0; m_rvld = 0;
      return;
    end
    rd = re && !we;
    wr = we && !re;
    m_rvld = rd;
    if (rd) begin
      m_rd = m_read(addr);
      exp_q.push_back(m_rd);
    end
    match = m_en && (m_count == m_cmp);
    m_edge = (m_edge & ~((wr && addr == 16'hC002) ? d[SWW-1:0] : '0)) | (m_s2 & ~m_s3);
    if (match) m_flag = 1;
    else if (wr && addr == 16'hC005 && d[2]) m_flag = 0;
    if (wr && addr == 16'hC003) m_count = d;
    else if (m_en) m_count = (match && m_ac) ? 16'h0000 : m_count + 16'h0001;
    if (wr && addr == 16'hC004) m_cmp = d;
    if (wr && addr == 16'hC005) begin
      m_en = d[0]; m_ac = d[1]; m_ie = d[3];
    end
    if (wr && addr == 16'hC000) m_led = d[LEDW-1:0];
    if (wr && in_mem(addr)) m_mem[addr[11:0]] = d;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = sw_v;
    m_irq = m_flag && m_ie;
  endtask

  task automatic cyc(input bit r, input bit rr, input bit ww, input logic [15:0] a,
                     input logic [15:0] d);
    rst = r; re = rr; we = ww; addr = a; wrt_data = d;
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_op(input logic [15:0] a);
    cyc(0, 1, 0, a, 16'h0000);
  endtask

  task automatic wr_op(input logic [15:0] a, input logic [15:0] d);
    cyc(0, 0, 1, a, d);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 16'h0000, 16'h0000);
  endtask

  // Monitor: compares every cycle, pops the scoreboard whenever a read completes.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("rd_data_state", rd_data, m_rd);
      chk("LEDR", {6'b0, LEDR}, {6'b0, m_led});
      chk("irq", {15'b0, irq}, {15'b0, m_irq});
      if (m_rvld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_pop actual=%h expected=<empty queue>", rd_data);
        end else begin
          chk("rd_pop", rd_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int rise;
    int k;
    int op;
    logic [15:0] a, d;

    sw_v = '0;
    rst = 1; re = 0; we = 0; addr = 0; wrt_data = 0;
    repeat (3) cyc(1, 0, 0, 16'h0000, 16'h0000);
    mon_on = 1;
    chk("reset_rd_data", rd_data, 16'h0000);
    chk("reset_LEDR", {6'b0, LEDR}, 16'h0000);
    chk("reset_irq", {15'b0, irq}, 16'h0000);

    // First access right after reset release, then the whole register map.
    rd_op(16'hC004);
    chk("reset_cmp", rd_data, 16'hFFFF);
    for (int i = 0; i < 6; i++) rd_op(16'hC000 + 16'(i));

    for (int i = 0; i < 32; i++) wr_op(16'(i), 16'($urandom));

    wr_op(16'h0010, 16'hBEEF);
    rd_op(16'h0010);
    chk("mem_beef", rd_data, 16'hBEEF);
    rd_op(16'h1FFF);
    chk("mem_oor_zero", rd_data, 16'h0000);
    wr_op(16'h1010, 16'h1234);
    rd_op(16'h1010);
    rd_op(16'h0010);
    chk("mem_no_alias", rd_data, 16'hBEEF);

    wr_op(16'hC000, 16'h03FF);
    chk("led_write", {6'b0, LEDR}, 16'h03FF);
    rd_op(16'hC000);
    cyc(0, 1, 1, 16'hC000, 16'h0000);
    chk("collide_led", {6'b0, LEDR}, 16'h03FF);
    chk("collide_rd_hold", rd_data, 16'h03FF);

    sw_v = 10'h001;
    idle();
    idle();
    rd_op(16'hC001);
    chk("sw_sync", rd_data, 16'h0001);
    rd_op(16'hC002);
    chk("edge_set", rd_data, 16'h0001);
    wr_op(16'hC002, 16'h0001);
    rd_op(16'hC002);
    chk("edge_clear", rd_data, 16'h0000);
    sw_v = 10'h000;
    repeat (3) idle();
    sw_v = 10'h001;
    idle();
    idle();
    wr_op(16'hC002, 16'h0001);
    rd_op(16'hC002);
    chk("edge_set_wins", rd_data, 16'h0001);

    wr_op(16'hC003, 16'h0000);
    wr_op(16'hC004, 16'h0005);
    wr_op(16'hC005, 16'h000B);
    rise = 0;
    for (int j = 1; j <= 20; j++) begin
      idle();
      if (irq === 1'b1) begin
        rise = j;
        break;
      end
    end
    chk("irq_rise_cycles", 16'(rise), 16'd6);
    rd_op(16'hC003);
    chk("autoclr_count", rd_data, 16'h0000);
    wr_op(16'hC005, 16'h0004);
    chk("irq_fall", {15'b0, irq}, 16'h0000);

    wr_op(16'hC003, 16'hFFFE);
    wr_op(16'hC004, 16'h0000);
    wr_op(16'hC005, 16'h0009);
    rd_op(16'hC003);
    chk("wrap_fffe", rd_data, 16'hFFFE);
    rd_op(16'hC003);
    chk("wrap_ffff", rd_data, 16'hFFFF);
    rd_op(16'hC003);
    chk("wrap_0000", rd_data, 16'h0000);
    rd_op(16'hC005);
    chk("wrap_flag", rd_data, 16'h000D);
    chk("wrap_irq", {15'b0, irq}, 16'h0001);
    cyc(1, 1, 1, 16'hC000, 16'hFFFF);
    chk("midrst_rd_data", rd_data, 16'h0000);
    chk("midrst_LEDR", {6'b0, LEDR}, 16'h0000);
    chk("midrst_irq", {15'b0, irq}, 16'h0000);
    rd_op(16'hC004);
    chk("midrst_cmp", rd_data, 16'hFFFF);
    rd_op(16'hC003);
    chk("midrst_count", rd_data, 16'h0000);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) sw_v = SWW'($urandom);
      k = $urandom_range(0, 9);
      d = 16'($urandom);
      case (k)
        0, 1, 2, 3, 5: a = 16'hC000 + 16'(k);
        4:       begin a = 16'hC003 + 16'($urandom_range(0, 1)); d = 16'($urandom_range(0, 40)); end
        6:       a = 16'($urandom_range(0, 31));
        7:       a = 16'h1000 + 16'($urandom_range(0, 4095));
        8:       a = {3'($urandom_range(1, 5)), 13'($urandom)};
        default: a = 16'hC006 + 16'($urandom_range(0, 9));
      endcase
      op = $urandom_range(0, 3);
      cyc(($urandom_range(0, 63) == 0), op[0], op[1], a, d);
    end

    idle();
    idle();
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
